// File: rtl/packed_pixel_unpacker.sv
// packed_pixel_unpacker
// Expands 16-pixel packed SDRAM words, LSB first, into one VGA pixel per
// request. A one-word prefetch register keeps requests running at full rate.
// Pixels that arrive while no bits are buffered come out as black, and they
// raise a sticky underrun flag.
module packed_pixel_unpacker #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int WORD_BITS = 16
) (
    input  logic                 iCLK,
    input  logic                 iRST_N,
    input  logic                 iPIX_REQ,
    input  logic                 iFRAME_START,
    input  logic                 iRD_EMPTY,
    output logic                 oRD,
    input  logic [WORD_BITS-1:0] iRD_DATA,
    output logic                 oPIX_VALID,
    output logic [9:0]           oPIX_DATA,
    output logic [9:0]           oX,
    output logic [8:0]           oY,
    output logic                 oFRAME_DONE,
    output logic                 oUNDERRUN
);

    localparam int CW = $clog2(WORD_BITS + 1);

    logic [WORD_BITS-1:0] r_cur;
    logic [CW-1:0]        r_cnt;
    logic [WORD_BITS-1:0] r_nxt;
    logic                 r_nxt_vld;
    logic                 r_pend;
    logic [9:0]           r_x;
    logic [8:0]           r_y;
    logic                 r_pix_valid;
    logic [9:0]           r_pix_data;
    logic [9:0]           r_ox;
    logic [8:0]           r_oy;
    logic                 r_frame_done;
    logic                 r_underrun;

    logic w_req;
    logic w_have;
    logic w_consume;
    logic w_exhaust;
    logic w_load;
    logic w_capture;
    logic w_rd;
    logic w_x_last;
    logic w_y_last;

    // A resync pulse swallows any request in the same cycle.
    assign w_req     = iPIX_REQ && !iFRAME_START;
    assign w_have    = (r_cnt != '0);
    assign w_consume = w_req && w_have;
    // cur is empty at the end of this cycle, either already or after this pixel.
    assign w_exhaust = !w_have || ((r_cnt == CW'(1)) && w_consume);
    assign w_load    = w_exhaust && r_nxt_vld && !iFRAME_START;
    // Data for a read issued before a resync belongs to the old frame.
    assign w_capture = r_pend && !iFRAME_START;
    // Only one read may be in flight, and only when nxt has room by cycle end.
    // The read is also gated while reset is held.
    assign w_rd      = iRST_N && !r_pend && !iRD_EMPTY && !iFRAME_START
                       && (!r_nxt_vld || w_load);
    assign w_x_last  = (r_x == 10'(H_ACTIVE - 1));
    assign w_y_last  = (r_y == 9'(V_ACTIVE - 1));

    // Shift register, prefetch word and read-outstanding tracking.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_cur     <= '0;
            r_cnt     <= '0;
            r_nxt     <= '0;
            r_nxt_vld <= 1'b0;
            r_pend    <= 1'b0;
        end else if (iFRAME_START) begin
            r_cur     <= '0;
            r_cnt     <= '0;
            r_nxt_vld <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (w_load) begin
                r_cur <= r_nxt;
                r_cnt <= CW'(WORD_BITS);
            end else if (w_consume) begin
                r_cur <= r_cur >> 1;
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_capture) begin
                r_nxt     <= iRD_DATA;
                r_nxt_vld <= 1'b1;
            end else if (w_load) begin
                r_nxt_vld <= 1'b0;
            end
            if (w_rd) begin
                r_pend <= 1'b1;
            end else if (w_capture) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Raster position of the next pixel to be emitted.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_x <= '0;
            r_y <= '0;
        end else if (iFRAME_START) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_req) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? 9'd0 : r_y + 9'd1;
            end else begin
                r_x <= r_x + 10'd1;
            end
        end
    end

    // Registered pixel outputs, one cycle after the request.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_pix_valid  <= 1'b0;
            r_pix_data   <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_frame_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_pix_valid  <= w_req;
            r_frame_done <= w_req && w_x_last && w_y_last;
            if (w_req) begin
                r_pix_data <= (w_have && r_cur[0]) ? 10'h3FF : 10'h000;
                r_ox       <= r_x;
                r_oy       <= r_y;
                if (!w_have) begin
                    r_underrun <= 1'b1;
                end
            end
        end
    end

    assign oRD         = w_rd;
    assign oPIX_VALID  = r_pix_valid;
    assign oPIX_DATA   = r_pix_data;
    assign oX          = r_ox;
    assign oY          = r_oy;
    assign oFRAME_DONE = r_frame_done;
    assign oUNDERRUN   = r_underrun;

endmodule

// File: tb/tb_packed_pixel_unpacker.sv
// Testbench for packed_pixel_unpacker: a FIFO model plus a bit-queue
// reference model, compared against the DUT every cycle.
module tb_packed_pixel_unpacker;

    localparam int H  = 32;
    localparam int V  = 2;
    localparam int WB = 16;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic          iPIX_REQ = 1'b0;
    logic          iFRAME_START = 1'b0;
    logic          iRD_EMPTY = 1'b1;
    logic          oRD;
    logic [WB-1:0] iRD_DATA = '0;
    logic          oPIX_VALID;
    logic [9:0]    oPIX_DATA;
    logic [9:0]    oX;
    logic [8:0]    oY;
    logic          oFRAME_DONE;
    logic          oUNDERRUN;

    always #5 iCLK = ~iCLK;

    packed_pixel_unpacker #(.H_ACTIVE(H), .V_ACTIVE(V), .WORD_BITS(WB)) dut (
        .iCLK        (iCLK),
        .iRST_N      (iRST_N),
        .iPIX_REQ    (iPIX_REQ),
        .iFRAME_START(iFRAME_START),
        .iRD_EMPTY   (iRD_EMPTY),
        .oRD         (oRD),
        .iRD_DATA    (iRD_DATA),
        .oPIX_VALID  (oPIX_VALID),
        .oPIX_DATA   (oPIX_DATA),
        .oX          (oX),
        .oY          (oY),
        .oFRAME_DONE (oFRAME_DONE),
        .oUNDERRUN   (oUNDERRUN)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    bit          m_cur[$];
    logic [15:0] m_nxt[$];
    bit          m_pend;
    int          m_x, m_y;
    logic        e_valid, e_done, e_und, e_rd;
    logic [9:0]  e_data, e_x;
    logic [8:0]  e_y;

    logic [15:0] fifo[$];
    logic [15:0] words[6];
    bit          force_empty = 1'b1;
    int          done_count;
    int          rd_seen;
    logic [9:0]  got_d[$];
    logic [9:0]  got_x[$];
    logic [8:0]  got_y[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cur.delete();
        m_nxt.delete();
        m_pend = 0;
        m_x = 0; m_y = 0;
        e_valid = 0; e_done = 0; e_und = 0; e_rd = 0;
        e_data = '0; e_x = '0; e_y = '0;
    endtask

    // One clock of behaviour, from the inputs currently applied.
    task automatic model_step();
        bit          was_pend;
        logic [15:0] w;
        was_pend = m_pend;
        e_rd = 0;
        if (!iRST_N) begin
            model_reset();
            return;
        end
        if (iFRAME_START) begin
            m_cur.delete();
            m_nxt.delete();
            m_pend = 0;
            m_x = 0; m_y = 0;
            e_valid = 0; e_done = 0;
            return;
        end
        if (iPIX_REQ) begin
            e_valid = 1;
            e_x = 10'(m_x);
            e_y = 9'(m_y);
            e_done = (m_x == H - 1) && (m_y == V - 1);
            if (m_cur.size() > 0) begin
                e_data = m_cur.pop_front() ? 10'h3FF : 10'h000;
            end else begin
                e_data = 10'h000;
                e_und = 1;
            end
            m_x++;
            if (m_x == H) begin
                m_x = 0;
                m_y++;
                if (m_y == V) m_y = 0;
            end
        end else begin
            e_valid = 0;
            e_done = 0;
        end
        if (m_cur.size() == 0 && m_nxt.size() > 0) begin
            w = m_nxt.pop_front();
            for (int i = 0; i < WB; i++) m_cur.push_back(w[i]);
        end
        if (was_pend) begin
            m_nxt.push_back(iRD_DATA);
            m_pend = 0;
        end
        if (!was_pend && !iRD_EMPTY && m_nxt.size() == 0) begin
            e_rd = 1;
            m_pend = 1;
        end
    endtask

    task automatic cycle(input bit req, input bit fs);
        iPIX_REQ = req;
        iFRAME_START = fs;
        iRD_EMPTY = force_empty || (fifo.size() == 0);
        @(negedge iCLK);
        model_step();
        check("oRD", oRD, e_rd);
        if (oRD) rd_seen++;
        @(posedge iCLK);
        #1;
        if (e_rd && fifo.size() > 0) iRD_DATA = fifo.pop_front();
        else iRD_DATA = 16'($urandom);
        check("valid", oPIX_VALID, e_valid);
        check("data", oPIX_DATA, e_data);
        check("x", oX, e_x);
        check("y", oY, e_y);
        check("frame_done", oFRAME_DONE, e_done);
        check("underrun", oUNDERRUN, e_und);
        if (oPIX_VALID) begin
            $display("PIX x=%0d y=%0d data=%h done=%0d und=%0d",
                     oX, oY, oPIX_DATA, oFRAME_DONE, oUNDERRUN);
            got_d.push_back(oPIX_DATA);
            got_x.push_back(oX);
            got_y.push_back(oY);
        end
        if (oFRAME_DONE) done_count++;
    endtask

    task automatic start_frame(input int n);
        force_empty = 1;
        fifo.delete();
        cycle(0, 1);
        for (int i = 0; i < n; i++) fifo.push_back(words[i]);
        force_empty = 0;
        repeat (8) cycle(0, 0);
        got_d.delete(); got_x.delete(); got_y.delete();
        done_count = 0;
    endtask

    initial begin
        logic [15:0] wv;
        model_reset();

        // reset held with random inputs
        iRST_N = 0;
        for (int i = 0; i < 6; i++) fifo.push_back(16'($urandom));
        for (int i = 0; i < 6; i++) begin
            force_empty = 1'($urandom);
            cycle(1'($urandom), 1'($urandom));
        end
        iRST_N = 1;
        force_empty = 0;
        rd_seen = 0;
        cycle(0, 0);
        cycle(0, 0);
        check("rd_after_reset", (rd_seen > 0), 1);

        // bit order, back to back
        words[0] = 16'h8001; words[1] = 16'h00FF;
        for (int i = 2; i < 6; i++) words[i] = 16'($urandom);
        start_frame(4);
        repeat (32) cycle(1, 0);
        for (int i = 0; i < 32; i++) begin
            wv = words[i / 16];
            check("bitord_d", got_d[i], wv[i % 16] ? 10'h3FF : 10'h000);
            check("bitord_x", got_x[i], i);
        end

        // line and frame wrap
        for (int i = 0; i < 6; i++) words[i] = 16'($urandom);
        start_frame(6);
        repeat (65) cycle(1, 0);
        check("wrap_count", got_d.size(), 65);
        check("wrap_y31", got_y[31], 0);
        check("wrap_y32", got_y[32], 1);
        check("wrap_x32", got_x[32], 0);
        check("wrap_done_cnt", done_count, 1);
        check("wrap_x64", got_x[64], 0);
        check("wrap_y64", got_y[64], 0);

        // gapped requests reproduce the same sequence
        words[0] = 16'h8001; words[1] = 16'h00FF; words[2] = 16'($urandom);
        start_frame(3);
        for (int p = 0; p < 48; p++) begin
            cycle(1, 0);
            cycle(0, 0);
            cycle(0, 0);
        end
        for (int i = 0; i < 48; i++) begin
            wv = words[i / 16];
            check("gap_d", got_d[i], wv[i % 16] ? 10'h3FF : 10'h000);
        end

        // underrun
        force_empty = 1;
        fifo.delete();
        cycle(0, 1);
        got_d.delete(); got_x.delete(); got_y.delete();
        repeat (3) cycle(1, 0);
        check("und_flag", oUNDERRUN, 1);
        for (int i = 0; i < 3; i++) begin
            check("und_d", got_d[i], 10'h000);
            check("und_x", got_x[i], i);
        end
        cycle(0, 1);
        check("und_sticky", oUNDERRUN, 1);

        // resync while a read is returning and a request is present
        for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
        start_frame(4);
        force_empty = 1;
        repeat (17) cycle(1, 0);
        force_empty = 0;
        cycle(0, 0);
        check("resync_rd", rd_seen > 0, 1);
        cycle(1, 1);
        check("resync_novalid", oPIX_VALID, 0);
        got_d.delete(); got_x.delete(); got_y.delete();
        repeat (6) cycle(0, 0);
        cycle(1, 0);
        wv = words[3];
        check("resync_d", got_d[0], wv[0] ? 10'h3FF : 10'h000);
        check("resync_x", got_x[0], 0);
        check("resync_y", got_y[0], 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
